// File: rtl/pattern_gen_pkg.sv
// Shared types and constants for the pattern_gen slice.
// LFSR tap masks are used only when PATTERN_GEN_LFSR_EN is defined.
package pattern_gen_pkg;

  typedef enum logic [1:0] {
    CONST  = 2'd0,
    COUNT  = 2'd1,
    TOGGLE = 2'd2,
    LFSR   = 2'd3
  } mode_e;

  typedef enum logic {
    CH_IDLE   = 1'b0,
    CH_ACTIVE = 1'b1
  } ch_state_e;

  // Galois feedback masks for shift-right LFSRs of the supported widths.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      default: return 32'h8020_0003;
    endcase
  endfunction

endpackage

// File: rtl/pattern_gen_ch.sv
// One pattern channel: burst FSM, remaining-length down-counter and sample generator.
// Mode 3 is a Galois LFSR only when PATTERN_GEN_LFSR_EN is defined, otherwise it holds like CONST.
//
// state     | meaning
// ----------+---------------------------------------------------------
// CH_IDLE   | no burst; channel may accept a new configuration
// CH_ACTIVE | burst in progress; sample is offered to the arbiter
module pattern_gen_ch
  import pattern_gen_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  mode_e            cfg_mode,
  input  logic [WIDTH-1:0] cfg_seed,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             load,
  output logic             active,
  output logic             last,
  output logic [WIDTH-1:0] sample
);

  ch_state_e        state, state_nxt;
  mode_e            mode;
  logic [LEN_W-1:0] remaining;
  logic [WIDTH-1:0] cur, gen_next, seed_init;

`ifdef PATTERN_GEN_LFSR_EN
  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));
  // An all-zero LFSR would lock up, so a zero seed starts at 1.
  assign seed_init = (cfg_mode == LFSR && cfg_seed == '0) ? WIDTH'(1) : cfg_seed;
`else
  assign seed_init = cfg_seed;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CH_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CH_IDLE:   if (cfg_we && cfg_len != '0) state_nxt = CH_ACTIVE;
      CH_ACTIVE: if (load && remaining == LEN_W'(1)) state_nxt = CH_IDLE;
      default:   state_nxt = CH_IDLE;
    endcase
  end

  always_comb begin
    active = (state == CH_ACTIVE);
    last   = (remaining == LEN_W'(1));
    sample = cur;
  end

  always_comb begin
    gen_next = cur;
    case (mode)
      COUNT:  gen_next = cur + WIDTH'(1);
      TOGGLE: gen_next = ~cur;
`ifdef PATTERN_GEN_LFSR_EN
      LFSR:   gen_next = (cur >> 1) ^ (cur[0] ? TAPS : '0);
`endif
      default: gen_next = cur;
    endcase
  end

  // cfg_we only arrives while idle and load only while active, so they never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      cur       <= '0;
      mode      <= CONST;
    end else if (cfg_we && cfg_len != '0) begin
      remaining <= cfg_len;
      cur       <= seed_init;
      mode      <= cfg_mode;
    end else if (load) begin
      remaining <= remaining - LEN_W'(1);
      cur       <= gen_next;
    end
  end

endmodule

// File: rtl/pattern_gen.sv
// Multi-channel test-pattern generator: NUM_CH channels merged by a round-robin arbiter
// onto one valid/ready stream. Optional LFSR mode is enabled by PATTERN_GEN_LFSR_EN.
module pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter  int NUM_CH    = 4,
  parameter  int WIDTH     = 8,
  parameter  int BURST_MAX = 16,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LEN_W     = $clog2(BURST_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [WIDTH-1:0]  cfg_seed,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_last,
  output logic [NUM_CH-1:0] busy
);

  logic [NUM_CH-1:0] active, last, cfg_we, ch_load;
  logic [WIDTH-1:0]  samples [NUM_CH];
  logic [LEN_W-1:0]  len_clamped;
  logic [CH_W-1:0]   rr_ptr, grant;
  logic              cfg_acc, grant_found, load;

  assign busy        = active;
  assign len_clamped = (cfg_len > LEN_W'(BURST_MAX)) ? LEN_W'(BURST_MAX) : cfg_len;
  assign cfg_acc     = cfg_valid && cfg_ready;

  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++)
      if (cfg_ch == CH_W'(i)) cfg_ready = !busy[i];
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign cfg_we[g]  = cfg_acc && (cfg_ch == CH_W'(g));
    assign ch_load[g] = load && (grant == CH_W'(g));

    pattern_gen_ch #(.WIDTH(WIDTH), .LEN_W(LEN_W)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .cfg_we   (cfg_we[g]),
      .cfg_mode (mode_e'(cfg_mode)),
      .cfg_seed (cfg_seed),
      .cfg_len  (len_clamped),
      .load     (ch_load[g]),
      .active   (active[g]),
      .last     (last[g]),
      .sample   (samples[g])
    );
  end

  // Round-robin: channels above the last grant first, then wrap to the rest.
  always_comb begin
    grant       = rr_ptr;
    grant_found = 1'b0;
    for (int j = 0; j < NUM_CH; j++)
      if (!grant_found && active[j] && CH_W'(j) > rr_ptr) begin
        grant       = CH_W'(j);
        grant_found = 1'b1;
      end
    for (int j = 0; j < NUM_CH; j++)
      if (!grant_found && active[j] && CH_W'(j) <= rr_ptr) begin
        grant       = CH_W'(j);
        grant_found = 1'b1;
      end
  end

  assign load = (!out_valid || out_ready) && (|active);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
      rr_ptr    <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= samples[grant];
      out_ch    <= grant;
      out_last  <= last[grant];
      rr_ptr    <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// Self-checking bench for pattern_gen: per-channel expected-sample queues plus directed scenarios.
// Expected LFSR values depend on PATTERN_GEN_LFSR_EN.
module tb_pattern_gen;

  localparam int NUM_CH = 4, WIDTH = 8, BURST_MAX = 16;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       cfg_valid, cfg_ready, out_valid, out_ready, out_last;
  logic [1:0] cfg_ch, cfg_mode, out_ch;
  logic [7:0] cfg_seed, out_data;
  logic [4:0] cfg_len;
  logic [3:0] busy;

  always #5 clk = ~clk;

  pattern_gen #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_seed(cfg_seed), .cfg_len(cfg_len), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch), .out_last(out_last), .busy(busy)
  );

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] data; logic last; } smp_t;
  typedef struct { int ch; logic [7:0] data; logic last; int cyc; } rec_t;
  smp_t exp_q [NUM_CH][$];
  rec_t log_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Sample k of a burst, computed directly from the pattern rules.
  function automatic logic [7:0] model_sample(input int mode, input logic [7:0] seed, input int k);
`ifdef PATTERN_GEN_LFSR_EN
    logic [7:0] s;
`endif
    case (mode)
      1: return seed + 8'(k);
      2: return (k % 2 == 1) ? ~seed : seed;
      3: begin
`ifdef PATTERN_GEN_LFSR_EN
        s = (seed == 8'h00) ? 8'h01 : seed;
        repeat (k) s = s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
        return s;
`else
        return seed;
`endif
      end
      default: return seed;
    endcase
  endfunction

  logic       prev_stall = 1'b0, prev_last;
  logic [7:0] prev_data;
  logic [1:0] prev_ch;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
      prev_stall = 1'b0;
    end else begin
      check("cfg_ready_rule", 32'(cfg_ready), 32'(!busy[cfg_ch]));
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'(1));
        check("hold_data", 32'(out_data), 32'(prev_data));
        check("hold_ch", 32'(out_ch), 32'(prev_ch));
        check("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q[out_ch].size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_sample: ch %0d data %0h, expected no sample", out_ch, out_data);
        end else begin
          smp_t e;
          e = exp_q[out_ch].pop_front();
          check("stream_data", 32'(out_data), 32'(e.data));
          check("stream_last", 32'(out_last), 32'(e.last));
        end
        log_q.push_back('{int'(out_ch), out_data, out_last, cyc});
      end
      if (cfg_valid && cfg_ready) begin
        int len;
        len = (int'(cfg_len) > BURST_MAX) ? BURST_MAX : int'(cfg_len);
        for (int k = 0; k < len; k++)
          exp_q[cfg_ch].push_back('{model_sample(int'(cfg_mode), cfg_seed, k), k == len - 1});
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_ch    = out_ch;
      prev_last  = out_last;
    end
  end

  task automatic do_cfg(input int ch, input int mode, input logic [7:0] seed, input int len,
                        output int stalls, output int acc_cyc);
    bit done;
    done      = 1'b0;
    stalls    = 0;
    acc_cyc   = -1;
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_mode  = 2'(mode);
    cfg_seed  = seed;
    cfg_len   = 5'(len);
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge clk);
      if (cfg_ready) begin
        done    = 1'b1;
        acc_cyc = cyc;
      end else stalls++;
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL cfg_timeout: ch %0d never accepted, expected acceptance", ch);
    end
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while ((busy != 4'b0 || out_valid) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check(name, 32'(busy != 4'b0 || out_valid), 32'(0));
  endtask

  logic [7:0] t1_d [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
  logic [7:0] t2_d [5] = '{8'h5A, 8'h11, 8'hA5, 8'h11, 8'h5A};
  int         t2_c [5] = '{1, 2, 1, 2, 1};
  logic [7:0] t4_d [5] = '{8'h10, 8'h11, 8'h12, 8'h77, 8'h77};
`ifdef PATTERN_GEN_LFSR_EN
  logic [7:0] t5_d [3] = '{8'h01, 8'hB8, 8'h5C};
`else
  logic [7:0] t5_d [3] = '{8'h00, 8'h00, 8'h00};
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, a, s2, a2, n;
    cfg_valid = 0; cfg_ch = 0; cfg_mode = 0; cfg_seed = 0; cfg_len = 0; out_ready = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1;
    @(posedge clk); #1;
    check("rst_cfg_ready", 32'(cfg_ready), 32'(1));

    // COUNT wrap on channel 0
    out_ready = 1; log_q.delete();
    do_cfg(0, 1, 8'hFE, 4, s, a);
    wait_idle("t1_idle");
    check("t1_count", 32'(log_q.size()), 32'(4));
    if (log_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("t1_data", 32'(log_q[i].data), 32'(t1_d[i]));
        check("t1_last", 32'(log_q[i].last), 32'(i == 3));
        check("t1_ch", 32'(log_q[i].ch), 32'(0));
      end
      check("t1_first_latency", 32'(log_q[0].cyc - a), 32'(2));
      check("t1_back_to_back", 32'(log_q[3].cyc - log_q[0].cyc), 32'(3));
    end
    check("t1_busy", 32'(busy), 0);

    // TOGGLE ch1 and CONST ch2 interleaved
    log_q.delete();
    do_cfg(1, 2, 8'h5A, 3, s, a);
    do_cfg(2, 0, 8'h11, 2, s, a);
    wait_idle("t2_idle");
    check("t2_count", 32'(log_q.size()), 32'(5));
    if (log_q.size() == 5)
      for (int i = 0; i < 5; i++) begin
        check("t2_ch", 32'(log_q[i].ch), 32'(t2_c[i]));
        check("t2_data", 32'(log_q[i].data), 32'(t2_d[i]));
      end

    // backpressure
    out_ready = 0; log_q.delete();
    do_cfg(0, 0, 8'h33, 3, s, a);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_valid", 32'(out_valid), 32'(1));
      check("t3_data", 32'(out_data), 32'(8'h33));
      check("t3_busy0", 32'(busy[0]), 32'(1));
      @(posedge clk); #1;
    end
    out_ready = 1;
    wait_idle("t3_idle");
    check("t3_count", 32'(log_q.size()), 32'(3));
    if (log_q.size() == 3)
      for (int i = 0; i < 3; i++) begin
        check("t3_data_rel", 32'(log_q[i].data), 32'(8'h33));
        check("t3_last", 32'(log_q[i].last), 32'(i == 2));
      end

    // config to busy channel stalls until the cycle after its last load
    log_q.delete();
    do_cfg(0, 1, 8'h10, 3, s, a);
    do_cfg(0, 0, 8'h77, 2, s2, a2);
    check("t4_stalls", 32'(s2), 32'(3));
    wait_idle("t4_idle");
    check("t4_count", 32'(log_q.size()), 32'(5));
    if (log_q.size() == 5) begin
      for (int i = 0; i < 5; i++) check("t4_data", 32'(log_q[i].data), 32'(t4_d[i]));
      check("t4_gap", 32'(log_q[3].cyc - log_q[2].cyc), 32'(2));
    end

    // zero length and over-length bursts
    log_q.delete();
    do_cfg(3, 1, 8'h00, 0, s, a);
    repeat (4) @(posedge clk);
    #1;
    check("t4_len0_busy", 32'(busy), 0);
    check("t4_len0_count", 32'(log_q.size()), 32'(0));
    do_cfg(3, 1, 8'h00, 31, s, a);
    wait_idle("t4_len31_idle");
    check("t4_len31_count", 32'(log_q.size()), 32'(16));
    if (log_q.size() == 16) begin
      check("t4_len31_final", 32'(log_q[15].data), 32'(8'h0F));
      check("t4_len31_last", 32'(log_q[15].last), 32'(1));
      check("t4_len31_notlast", 32'(log_q[14].last), 32'(0));
    end

    // mode 3 with seed 0
    log_q.delete();
    do_cfg(2, 3, 8'h00, 3, s, a);
    wait_idle("t5_idle");
    check("t5_count", 32'(log_q.size()), 32'(3));
    if (log_q.size() == 3)
      for (int i = 0; i < 3; i++) check("t5_data", 32'(log_q[i].data), 32'(t5_d[i]));

    // reset mid-burst
    do_cfg(1, 1, 8'h40, 10, s, a);
    repeat (3) @(posedge clk);
    #2;
    check("t6_pre_busy", 32'(busy[1]), 32'(1));
    rst_n = 0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 0);
    check("t6_rst_data", 32'(out_data), 0);
    check("t6_rst_ch", 32'(out_ch), 0);
    check("t6_rst_last", 32'(out_last), 0);
    check("t6_rst_busy", 32'(busy), 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1;
    n = log_q.size();
    repeat (10) @(posedge clk);
    #1;
    check("t6_no_samples", 32'(log_q.size()), 32'(n));
    check("t6_busy_after", 32'(busy), 0);
    check("t6_valid_after", 32'(out_valid), 0);
    check("t6_cfg_ready", 32'(cfg_ready), 32'(1));

    n = 0;
    for (int c = 0; c < NUM_CH; c++) n += exp_q[c].size();
    check("pending_samples", 32'(n), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
